// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_pkg
// Purpose  : Shared state encoding, framing constants and helpers for the
//            frequency-meter UART serialiser.
// Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_t;

  localparam int         DATA_BITS = 8;
  localparam logic       LINE_IDLE = 1'b1;

  // Bytes the frame generator emits; kept here so benches can reuse them.
  localparam logic [7:0] CHAR_P    = 8'h50;
  localparam logic [7:0] CHAR_CR   = 8'h0D;
  localparam logic [7:0] CHAR_LF   = 8'h0A;

  function automatic logic parity_bit(input logic [7:0] b, input logic odd);
    return (^b) ^ odd;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_baud_gen.sv
`default_nettype none
// ============================================================================
// Module   : uart_baud_gen
// Purpose  : Bit-period counter; flags the last clk cycle of each serial bit.
// Revision : 1.0 - initial release
// ============================================================================
module uart_baud_gen #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  input  logic en,
  output logic bit_end
);

  localparam int            CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] TERM = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (restart) begin
      r_cnt <= '0;
    end else if (en) begin
      r_cnt <= (r_cnt == TERM) ? '0 : r_cnt + 1'b1;
    end
  end

  assign bit_end = en & (r_cnt == TERM);

endmodule
`default_nettype wire

// File: rtl/uart_byte_tx.sv
`default_nettype none
// ============================================================================
// Module   : uart_byte_tx
// Purpose  : Byte-to-RS-232 serialiser with a one-byte holding register so
//            consecutive frames leave with no idle gap.
// Revision : 1.0 - initial release
// ============================================================================
module uart_byte_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] datain,
  input  logic       wrsig,
  output logic       tx,
  output logic       idle,
  output logic       overrun
);

  uart_state_t r_state;
  logic        r_wrsig_d;
  logic [7:0]  r_shift;
  logic        r_par;
  logic [7:0]  r_hold;
  logic        r_hold_full;
  logic [2:0]  r_bit_cnt;
  logic        r_tx;
  logic        r_idle;
  logic        r_overrun;

  logic        w_wr;
  logic        w_busy;
  logic        w_bit_end;
  logic        w_last_stop;
  logic        w_start_frame;
  logic [7:0]  w_next_byte;

  assign w_wr        = wrsig & ~r_wrsig_d;
  assign w_busy      = (r_state != IDLE);
  assign w_last_stop = (r_state == STOP) & w_bit_end & (r_bit_cnt == 3'(STOP_BITS - 1));

  // A new frame starts from IDLE on a write, or back-to-back at the end of STOP
  // when a byte is waiting (held) or arriving on that very cycle (bypass).
  assign w_start_frame = ((r_state == IDLE) & w_wr) | (w_last_stop & (r_hold_full | w_wr));
  assign w_next_byte   = (w_last_stop & r_hold_full) ? r_hold : datain;

  uart_baud_gen #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud (
    .clk     (clk),
    .rst_n   (rst_n),
    .restart (w_start_frame),
    .en      (w_busy),
    .bit_end (w_bit_end)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_wrsig_d   <= 1'b0;
      r_shift     <= '0;
      r_par       <= 1'b0;
      r_hold      <= '0;
      r_hold_full <= 1'b0;
      r_bit_cnt   <= '0;
      r_tx        <= LINE_IDLE;
      r_idle      <= 1'b1;
      r_overrun   <= 1'b0;
    end else begin
      r_wrsig_d <= wrsig;
      r_overrun <= 1'b0;

      if (w_start_frame) begin
        r_shift   <= w_next_byte;
        r_par     <= parity_bit(w_next_byte, PARITY_ODD != 0);
        r_tx      <= 1'b0;
        r_bit_cnt <= '0;
        r_state   <= START;
        r_idle    <= 1'b0;
      end else begin
        case (r_state)
          START: if (w_bit_end) begin
            r_tx      <= r_shift[0];
            r_shift   <= r_shift >> 1;
            r_bit_cnt <= '0;
            r_state   <= DATA;
          end
          DATA: if (w_bit_end) begin
            if (r_bit_cnt == 3'(DATA_BITS - 1)) begin
              r_bit_cnt <= '0;
              if (PARITY_EN != 0) begin
                r_tx    <= r_par;
                r_state <= PARITY;
              end else begin
                r_tx    <= LINE_IDLE;
                r_state <= STOP;
              end
            end else begin
              r_bit_cnt <= r_bit_cnt + 3'd1;
              r_tx      <= r_shift[0];
              r_shift   <= r_shift >> 1;
            end
          end
          PARITY: if (w_bit_end) begin
            r_tx      <= LINE_IDLE;
            r_bit_cnt <= '0;
            r_state   <= STOP;
          end
          STOP: if (w_bit_end) begin
            if (w_last_stop) begin
              r_state <= IDLE;
              r_idle  <= 1'b1;
            end else begin
              r_bit_cnt <= r_bit_cnt + 3'd1;
            end
          end
          default: ;
        endcase
      end

      // Holding register: refilled in the same cycle it is drained, so a write
      // on the final stop cycle never counts as an overrun.
      if (w_last_stop & r_hold_full) begin
        if (w_wr) r_hold <= datain;
        else      r_hold_full <= 1'b0;
      end else if (w_wr & w_busy & ~w_last_stop) begin
        if (r_hold_full) begin
          r_overrun <= 1'b1;
        end else begin
          r_hold      <= datain;
          r_hold_full <= 1'b1;
        end
      end
    end
  end

  assign tx      = r_tx;
  assign idle    = r_idle;
  assign overrun = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_uart_byte_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_byte_tx
// Purpose  : Directed bench for uart_byte_tx (8N1, 8E1 and 8O2 instances).
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_byte_tx;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] datain = 8'h00;
  logic       wrsig = 1'b0;
  logic       tx, idle, overrun;
  logic       tx_pe, idle_pe, overrun_pe;
  logic       tx_po, idle_po, overrun_po;

  always #5 clk = ~clk;

  uart_byte_tx dut (
    .clk(clk), .rst_n(rst_n), .datain(datain), .wrsig(wrsig),
    .tx(tx), .idle(idle), .overrun(overrun)
  );

  uart_byte_tx #(.PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) dut_pe (
    .clk(clk), .rst_n(rst_n), .datain(datain), .wrsig(wrsig),
    .tx(tx_pe), .idle(idle_pe), .overrun(overrun_pe)
  );

  uart_byte_tx #(.PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2)) dut_po (
    .clk(clk), .rst_n(rst_n), .datain(datain), .wrsig(wrsig),
    .tx(tx_po), .idle(idle_po), .overrun(overrun_po)
  );

  typedef struct {
    logic [7:0] data;
    logic [9:0] frame;     // {stop, data[7:0], start}, bit 0 leaves first
    logic       par_even;
  } vec_t;

  int         n_cmp = 0;
  int         n_bad = 0;
  logic [9:0] q_frames[$];
  int         q_wr_at[$];
  logic [7:0] q_wr_val[$];
  int         hold_len;
  int         ovr_at;
  bit         chk_par;
  logic       par_exp;

  task automatic chk(input string name, input int cyc, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cycle %0d: actual %b, required %b", name, cyc, act, exp);
    end
  endtask

  task automatic clr();
    q_frames.delete();
    q_wr_at.delete();
    q_wr_val.delete();
    hold_len = 1;
    ovr_at   = -1;
    chk_par  = 1'b0;
    par_exp  = 1'b0;
  endtask

  task automatic do_reset();
    wrsig = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset tx", 0, tx, 1'b1);
    chk("reset idle", 0, idle, 1'b1);
    chk("reset overrun", 0, overrun, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Cycle c is sampled on the falling edge after rising edge c-1; a write
  // scheduled at c raises wrsig just before rising edge c.
  task automatic run_seq(input string name, input int ncyc);
    int nfr;
    nfr = q_frames.size();
    for (int c = 0; c <= ncyc; c++) begin
      if (c > 0) begin
        int   k;
        int   b;
        logic e_tx;
        logic e_pe;
        logic e_po;
        k = c - 1;
        b = k / 16;
        e_tx = (k / 160 < nfr) ? q_frames[k / 160][(k % 160) / 16] : 1'b1;
        chk({name, " tx"}, c, tx, e_tx);
        chk({name, " idle"}, c, idle, (c > nfr * 160) ? 1'b1 : 1'b0);
        chk({name, " overrun"}, c, overrun, (c == ovr_at) ? 1'b1 : 1'b0);
        if (chk_par) begin
          e_pe = (b < 9) ? q_frames[0][b] : (b == 9) ? par_exp : 1'b1;
          e_po = (b < 9) ? q_frames[0][b] : (b == 9) ? ~par_exp : 1'b1;
          chk({name, " even tx"}, c, tx_pe, e_pe);
          chk({name, " odd tx"}, c, tx_po, e_po);
          chk({name, " even idle"}, c, idle_pe, (c > 176) ? 1'b1 : 1'b0);
          chk({name, " odd idle"}, c, idle_po, (c > 192) ? 1'b1 : 1'b0);
        end
      end
      wrsig  = 1'b0;
      datain = 8'($urandom);
      foreach (q_wr_at[i]) begin
        if (c >= q_wr_at[i] && c < q_wr_at[i] + hold_len) begin
          wrsig  = 1'b1;
          datain = q_wr_val[i];
        end
      end
      @(negedge clk);
    end
  endtask

  initial begin
    vec_t tbl[7];
    tbl[0] = '{8'h50, 10'h2A0, 1'b0};
    tbl[1] = '{8'h0D, 10'h21A, 1'b1};
    tbl[2] = '{8'h0A, 10'h214, 1'b0};
    tbl[3] = '{8'hA5, 10'h34A, 1'b0};
    tbl[4] = '{8'hFF, 10'h3FE, 1'b0};
    tbl[5] = '{8'h00, 10'h200, 1'b0};
    tbl[6] = '{8'h07, 10'h20E, 1'b1};

    for (int v = 0; v < 7; v++) begin
      do_reset();
      clr();
      q_frames.push_back(tbl[v].frame);
      q_wr_at.push_back(0);
      q_wr_val.push_back(tbl[v].data);
      chk_par = 1'b1;
      par_exp = tbl[v].par_even;
      run_seq($sformatf("vec%0d", v), 200);
    end

    // Second byte lands in the holding register mid-frame.
    do_reset(); clr();
    q_frames.push_back(10'h2A0); q_frames.push_back(10'h262);
    q_wr_at.push_back(0);  q_wr_val.push_back(8'h50);
    q_wr_at.push_back(20); q_wr_val.push_back(8'h31);
    run_seq("b2b", 360);

    // Third byte while holding is full is dropped.
    do_reset(); clr();
    q_frames.push_back(10'h21A); q_frames.push_back(10'h214);
    q_wr_at.push_back(0);  q_wr_val.push_back(8'h0D);
    q_wr_at.push_back(30); q_wr_val.push_back(8'h0A);
    q_wr_at.push_back(60); q_wr_val.push_back(8'hFF);
    ovr_at = 61;
    run_seq("ovr", 400);

    // Write on the final stop cycle, holding empty: bypass.
    do_reset(); clr();
    q_frames.push_back(10'h2A0); q_frames.push_back(10'h21A);
    q_wr_at.push_back(0);   q_wr_val.push_back(8'h50);
    q_wr_at.push_back(160); q_wr_val.push_back(8'h0D);
    run_seq("bypass", 360);

    // Write on the final stop cycle, holding full: swap, no overrun.
    do_reset(); clr();
    q_frames.push_back(10'h2A0); q_frames.push_back(10'h214); q_frames.push_back(10'h3FE);
    q_wr_at.push_back(0);   q_wr_val.push_back(8'h50);
    q_wr_at.push_back(20);  q_wr_val.push_back(8'h0A);
    q_wr_at.push_back(160); q_wr_val.push_back(8'hFF);
    run_seq("swap", 520);

    // Held strobe yields exactly one frame.
    do_reset(); clr();
    hold_len = 40;
    q_frames.push_back(10'h2AA);
    q_wr_at.push_back(0); q_wr_val.push_back(8'h55);
    run_seq("held", 200);

    // Reset during data bit 3 (a 0 bit of A5), then a clean frame.
    do_reset(); clr();
    q_frames.push_back(10'h34A);
    q_wr_at.push_back(0); q_wr_val.push_back(8'hA5);
    run_seq("pre-rst", 72);
    chk("mid-frame tx before reset", 73, tx, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("async reset tx", 73, tx, 1'b1);
    chk("async reset idle", 73, idle, 1'b1);
    chk("async reset overrun", 73, overrun, 1'b0);
    chk("async reset odd tx", 73, tx_po, 1'b1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    clr();
    q_frames.push_back(10'h34A);
    q_wr_at.push_back(0); q_wr_val.push_back(8'hA5);
    run_seq("post-rst", 200);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
